// File: rtl/l2_pkg.sv
// Shared constants, default widths and helper types for the L2 instruction responder.
package l2_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int ADDRESS_WIDTH_DEF   = 32;
  localparam int L2_BUS_WIDTH_DEF    = 32;
  localparam int MEM_DEPTH_LOG2_DEF  = 10;
  localparam int MEM_LATENCY_DEF     = 2;
  localparam int RESP_FIFO_DEPTH_DEF = 4;

  function automatic int l2_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEF-3:0] word_addr;
  } l2_req_t;

  typedef struct packed {
    logic [L2_BUS_WIDTH_DEF-1:0] data;
  } l2_resp_t;

endpackage

// File: rtl/l2_response_fifo.sv
// Synchronous response FIFO; head entry is always visible, full/empty from the extra pointer bit.
module l2_response_fifo
  import l2_pkg::*;
#(
  parameter int WIDTH = L2_BUS_WIDTH_DEF,
  parameter int DEPTH = RESP_FIFO_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = l2_clog2(DEPTH);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst_n == LOW) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/l2_instruction_responder.sv
// L2-side responder for L1 instruction misses: credit-limited requests, fixed-latency store
// read pipeline, in-order response FIFO.
module l2_instruction_responder
  import l2_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = ADDRESS_WIDTH_DEF,
  parameter int L2_BUS_WIDTH    = L2_BUS_WIDTH_DEF,
  parameter int MEM_DEPTH_LOG2  = MEM_DEPTH_LOG2_DEF,
  parameter int MEM_LATENCY     = MEM_LATENCY_DEF,
  parameter int RESP_FIFO_DEPTH = RESP_FIFO_DEPTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_address_to_l2_valid_ins,
  output logic                      o_address_to_l2_ready_ins,
  input  logic [ADDRESS_WIDTH-3:0]  i_address_to_l2_ins,
  output logic                      o_data_from_l2_valid_ins,
  input  logic                      i_data_from_l2_ready_ins,
  output logic [L2_BUS_WIDTH-1:0]   o_data_from_l2_ins,
  input  logic                      i_load_valid,
  input  logic [MEM_DEPTH_LOG2-1:0] i_load_address,
  input  logic [L2_BUS_WIDTH-1:0]   i_load_data
);

  localparam int CW = l2_clog2(RESP_FIFO_DEPTH) + 1;

  logic [L2_BUS_WIDTH-1:0]   r_store [0:(1 << MEM_DEPTH_LOG2)-1];
  logic [CW-1:0]             r_outstanding;
  logic [MEM_DEPTH_LOG2-1:0] w_index;
  logic                      w_accept;
  logic                      w_pop;
  logic                      w_push;
  logic [L2_BUS_WIDTH-1:0]   w_push_data;
  logic [L2_BUS_WIDTH-1:0]   w_head;
  logic                      w_fifo_empty;
  logic                      w_unused_fifo_full;
  logic                      w_unused_addr_bits;

  // Upper address bits alias onto the store.
  assign w_index            = i_address_to_l2_ins[MEM_DEPTH_LOG2-1:0];
  assign w_unused_addr_bits = ^i_address_to_l2_ins[ADDRESS_WIDTH-3:MEM_DEPTH_LOG2];

  assign o_address_to_l2_ready_ins = i_rst_n && (r_outstanding < CW'(RESP_FIFO_DEPTH));
  assign w_accept                  = i_address_to_l2_valid_ins && o_address_to_l2_ready_ins;
  assign o_data_from_l2_valid_ins  = !w_fifo_empty;
  assign w_pop                     = o_data_from_l2_valid_ins && i_data_from_l2_ready_ins;
  assign o_data_from_l2_ins        = o_data_from_l2_valid_ins ? w_head : '0;

  always_ff @(posedge i_clk) begin
    if (i_load_valid) r_store[i_load_address] <= i_load_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n == LOW) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // The FIFO write is the last pipeline stage, so only MEM_LATENCY-1 registers sit before it.
  generate
    if (MEM_LATENCY == 1) begin : g_direct
      assign w_push      = w_accept;
      assign w_push_data = r_store[w_index];
    end else begin : g_pipe
      logic [MEM_LATENCY-2:0]  r_pipe_valid;
      logic [L2_BUS_WIDTH-1:0] r_pipe_data [0:MEM_LATENCY-2];

      always_ff @(posedge i_clk) begin
        if (i_rst_n == LOW) begin
          r_pipe_valid <= '0;
        end else begin
          r_pipe_valid[0] <= w_accept;
          for (int i = 1; i < MEM_LATENCY - 1; i++) r_pipe_valid[i] <= r_pipe_valid[i-1];
        end
      end

      always_ff @(posedge i_clk) begin
        r_pipe_data[0] <= r_store[w_index];
        for (int i = 1; i < MEM_LATENCY - 1; i++) r_pipe_data[i] <= r_pipe_data[i-1];
      end

      assign w_push      = r_pipe_valid[MEM_LATENCY-2];
      assign w_push_data = r_pipe_data[MEM_LATENCY-2];
    end
  endgenerate

  l2_response_fifo #(
    .WIDTH (L2_BUS_WIDTH),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_unused_fifo_full),
    .o_empty     (w_fifo_empty)
  );

endmodule

// File: tb/tb_l2_instruction_responder.sv
// Directed bench for l2_instruction_responder with default parameters (latency 2, FIFO depth 4).
module tb_l2_instruction_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  int tests_run;
  int tests_failed;

  l2_instruction_responder dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_address_to_l2_valid_ins (req_valid),
    .o_address_to_l2_ready_ins (req_ready),
    .i_address_to_l2_ins       (req_addr),
    .o_data_from_l2_valid_ins  (rsp_valid),
    .i_data_from_l2_ready_ins  (rsp_ready),
    .o_data_from_l2_ins        (rsp_data),
    .i_load_valid              (load_valid),
    .i_load_address            (load_addr),
    .i_load_data               (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = '0;
    rsp_ready  = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;

    // Reset held with a pending request
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("[TB] reset cycle %0d ready=%0b valid=%0b data=0x%08h", c, req_ready, rsp_valid, rsp_data);
      check("reset_ready", {31'd0, req_ready}, 32'd0);
      check("reset_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_data", rsp_data, 32'd0);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;

    // Single read of [5]
    preload(10'd5, 32'h0050_0093);
    check("single_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 30'h5;
    tick();
    req_valid = 1'b0;
    check("single_lat1_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    $display("[TB] single read addr=0x5 valid=%0b data=0x%08h", rsp_valid, rsp_data);
    check("single_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_data", rsp_data, 32'h0050_0093);
    tick();
    check("single_one_cycle", {31'd0, rsp_valid}, 32'd0);
    check("single_data_zero", rsp_data, 32'd0);

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) preload(10'(i), 32'(i * 4));
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        req_valid = 1'b1;
        req_addr  = 30'(j);
        check("stream_ready", {31'd0, req_ready}, 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      $display("[TB] stream cycle %0d valid=%0b data=0x%08h", j, rsp_valid, rsp_data);
      if (j >= 1 && j <= 8) begin
        check("stream_valid", {31'd0, rsp_valid}, 32'd1);
        check("stream_data", rsp_data, 32'((j - 1) * 4));
      end else begin
        check("stream_idle", {31'd0, rsp_valid}, 32'd0);
      end
    end

    // Backpressure: only four credits
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = (c < 4) ? 30'(c) : 30'd4;
      $display("[TB] backpressure req %0d addr=0x%0h ready=%0b", c, req_addr, req_ready);
      check("bp_ready", {31'd0, req_ready}, (c < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("bp_stall_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_stall_data", rsp_data, 32'd0);
    tick();
    check("bp_stable_data", rsp_data, 32'd0);
    check("bp_still_full", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("bp_rel_data1", rsp_data, 32'd4);
    check("bp_rel_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 30'd5;
    check("bp_rel_data2", rsp_data, 32'd8);
    tick();
    req_valid = 1'b0;
    check("bp_rel_data3", rsp_data, 32'd12);
    tick();
    check("bp_late_data4", rsp_data, 32'd16);
    tick();
    check("bp_late_data5", rsp_data, 32'd20);
    tick();
    $display("[TB] backpressure drained valid=%0b", rsp_valid);
    check("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Address aliasing: 0x400 reads word [0]
    preload(10'd0, 32'h0BAD_0000);
    req_valid = 1'b1;
    req_addr  = 30'h400;
    tick();
    req_valid = 1'b0;
    tick();
    $display("[TB] alias addr=0x400 valid=%0b data=0x%08h", rsp_valid, rsp_data);
    check("alias_valid", {31'd0, rsp_valid}, 32'd1);
    check("alias_data", rsp_data, 32'h0BAD_0000);
    tick();

    // Load and read of the same index on the same edge
    preload(10'd3, 32'h11);
    req_valid  = 1'b1;
    req_addr   = 30'h3;
    load_valid = 1'b1;
    load_addr  = 10'd3;
    load_data  = 32'hAA;
    tick();
    req_valid  = 1'b0;
    load_valid = 1'b0;
    tick();
    $display("[TB] rbw read [3] data=0x%08h", rsp_data);
    check("rbw_old", rsp_data, 32'h11);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    $display("[TB] rbw reread [3] data=0x%08h", rsp_data);
    check("rbw_new", rsp_data, 32'hAA);
    tick();

    // Reset with three requests in flight
    rsp_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      req_valid = 1'b1;
      req_addr  = 30'(c);
      tick();
    end
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("[TB] post-reset idle %0d valid=%0b", c, rsp_valid);
      check("mid_rst_no_stale", {31'd0, rsp_valid}, 32'd0);
    end
    check("mid_rst_ready_back", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = 30'h2;
    tick();
    req_valid = 1'b0;
    check("mid_rst_lat1", {31'd0, rsp_valid}, 32'd0);
    tick();
    $display("[TB] post-reset read [2] valid=%0b data=0x%08h", rsp_valid, rsp_data);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("mid_rst_data", rsp_data, 32'd8);
    tick();
    check("mid_rst_done", {31'd0, rsp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
